fifo_core: RTL and testbench

//  Synchronous single-clock FIFO, the storage end of the push/pop FIFO interface.
//  The push side writes data_in; the pop side reads data_out.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_flag_gen.sv | 33 +++
 rtl/fifo_core.sv | 116 +++++++++++
 tb/tb_fifo_core.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
//   Shared constants, types and the fill-level helper for the single-clock
//   FIFO (fifo_core) and its flag generator (fifo_flag_gen).
//   Contents: BIT_DEPTH, WIDTH, DEPTH, FULL, ALMOST_FULL, ALMOST_EMPTY,
//             word_t, ptr_t, buffer_t, fill_level().
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int BIT_DEPTH    = 4;
    localparam int WIDTH        = 32;
    localparam int DEPTH        = 1 << BIT_DEPTH;
    localparam int FULL         = DEPTH - 1;
    localparam int ALMOST_FULL  = 10;
    localparam int ALMOST_EMPTY = 4;

    typedef logic [WIDTH-1:0]     word_t;
    typedef logic [BIT_DEPTH-1:0] ptr_t;
    typedef word_t [DEPTH-1:0]    buffer_t;

    // Occupancy from the pointer pair; the BIT_DEPTH-bit subtraction wraps
    // naturally, which is why one slot is always kept free.
    function automatic ptr_t fill_level(input ptr_t wr, input ptr_t rd);
        return ptr_t'(wr - rd);
    endfunction

endpackage

// File: rtl/fifo_flag_gen.sv
// ----------------------------------------------------------------------------
// fifo_flag_gen
//   Purely combinational status flags from the write/read pointers.
//   Also used by the FIFO checker model, so it carries no state.
//   Ports:
//     wr_ptr, rd_ptr  in   BIT_DEPTH  current pointers
//     empty           out  1          fill == 0
//     almost_empty    out  1          fill <= ALMOST_EMPTY
//     almost_full     out  1          fill >= ALMOST_FULL
//     full            out  1          fill == DEPTH-1
// ----------------------------------------------------------------------------
module fifo_flag_gen
    import fifo_pkg::*;
(
    input  ptr_t wr_ptr,
    input  ptr_t rd_ptr,
    output logic empty,
    output logic almost_empty,
    output logic almost_full,
    output logic full
);

    ptr_t fill;

    always_comb begin
        fill         = fill_level(wr_ptr, rd_ptr);
        empty        = (fill == '0);
        almost_empty = (fill <= ptr_t'(ALMOST_EMPTY));
        almost_full  = (fill >= ptr_t'(ALMOST_FULL));
        full         = (fill == ptr_t'(FULL));
    end

endmodule

// File: rtl/fifo_core.sv
// ----------------------------------------------------------------------------
// fifo_core
//   Synchronous single-clock FIFO storage with zero-latency read port.
//   Usable capacity is DEPTH-1 entries. Pointers and storage are exported so
//   a property checker can be bound directly.
//   Optional feature macro: FIFO_ERR_CNT_EN adds an 8-bit saturating count of
//   error cycles on port err_cnt.
//   Ports:
//     clk           in   1           clock, rising edge
//     reset         in   1           asynchronous, active-high
//     push / pop    in   1           write / read requests
//     data_in       in   WIDTH       write data
//     data_out      out  WIDTH       buffer[rd_ptr], combinational
//     empty, almost_empty, almost_full, full   out  status flags
//     error         out  1           illegal request this cycle
//     wr_ptr/rd_ptr out  BIT_DEPTH   pointers
//     buffer        out  DEPTH*WIDTH storage array
//     err_cnt       out  8           only with FIFO_ERR_CNT_EN
// ----------------------------------------------------------------------------
module fifo_core
    import fifo_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  logic    pop,
    input  word_t   data_in,
    output word_t   data_out,
    output logic    empty,
    output logic    almost_empty,
    output logic    almost_full,
    output logic    full,
    output logic    error,
    output ptr_t    wr_ptr,
    output ptr_t    rd_ptr,
    output buffer_t buffer
`ifdef FIFO_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    ptr_t    wr_ptr_q, wr_ptr_d;
    ptr_t    rd_ptr_q, rd_ptr_d;
    buffer_t buffer_q, buffer_d;
    logic    push_ok, pop_ok;

    fifo_flag_gen u_flags (
        .wr_ptr       (wr_ptr_q),
        .rd_ptr       (rd_ptr_q),
        .empty        (empty),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .full         (full)
    );

    always_comb begin
        // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
        push_ok  = push && (!full || pop);
        pop_ok   = pop && !empty;
        error    = (push && full && !pop) || (pop && empty);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        buffer_d = buffer_q;
        if (push_ok) begin
            buffer_d[wr_ptr_q] = data_in;
            wr_ptr_d           = wr_ptr_q + ptr_t'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately not reset; emptiness is carried by the pointers.
    always_ff @(posedge clk) begin
        buffer_q <= buffer_d;
    end

    assign data_out = buffer_q[rd_ptr_q];
    assign wr_ptr   = wr_ptr_q;
    assign rd_ptr   = rd_ptr_q;
    assign buffer   = buffer_q;

`ifdef FIFO_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (error && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_core.sv
// ----------------------------------------------------------------------------
// tb_fifo_core
//   Self-checking bench for fifo_core: a short table of directed vectors,
//   hand-written corner sequences, and a randomized run compared against a
//   queue-based reference model.
// ----------------------------------------------------------------------------
module tb_fifo_core;
    import fifo_pkg::*;

    logic    clk;
    logic    reset;
    logic    push;
    logic    pop;
    word_t   data_in;
    word_t   data_out;
    logic    empty, almost_empty, almost_full, full, error;
    ptr_t    wr_ptr, rd_ptr;
    buffer_t buffer;
`ifdef FIFO_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    fifo_core dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .data_in      (data_in),
        .data_out     (data_out),
        .empty        (empty),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .full         (full),
        .error        (error),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .buffer       (buffer)
`ifdef FIFO_ERR_CNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a plain queue of words plus pointer counters.
    word_t mq[$];
    int    m_pushes;
    int    m_pops;
    int    m_errcnt;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_pushes = 0;
        m_pops   = 0;
        m_errcnt = 0;
    endfunction

    // Compare all combinational outputs against the model (call away from the edge).
    task automatic model_check(input logic p, input logic q);
        int sz;
        sz = mq.size();
        check("empty",        empty,        sz == 0);
        check("almost_empty", almost_empty, sz <= ALMOST_EMPTY);
        check("almost_full",  almost_full,  sz >= ALMOST_FULL);
        check("full",         full,         sz == DEPTH - 1);
        check("error",        error,        (p && sz == DEPTH - 1 && !q) || (q && sz == 0));
        check("wr_ptr",       wr_ptr,       m_pushes % DEPTH);
        check("rd_ptr",       rd_ptr,       m_pops % DEPTH);
        if (sz > 0) check("data_out", data_out, mq[0]);
`ifdef FIFO_ERR_CNT_EN
        check("err_cnt",      err_cnt,      m_errcnt);
`endif
    endtask

    function automatic void model_update(input logic p, input logic q, input word_t d);
        int  sz;
        bit  p_ok, q_ok;
        sz   = mq.size();
        q_ok = q && sz > 0;
        p_ok = p && (sz < DEPTH - 1 || q);
        if ((p && sz == DEPTH - 1 && !q) || (q && sz == 0))
            m_errcnt = (m_errcnt < 255) ? m_errcnt + 1 : 255;
        if (q_ok) begin
            void'(mq.pop_front());
            m_pops++;
        end
        if (p_ok) begin
            mq.push_back(d);
            m_pushes++;
        end
    endfunction

    // One clock: drive, check at negedge, advance at posedge.
    task automatic step(input logic p, input logic q, input word_t d);
        push = p; pop = q; data_in = d;
        @(negedge clk);
        model_check(p, q);
        @(posedge clk);
        #1;
        model_update(p, q, d);
    endtask

    task automatic do_reset();
        push = 1'b0; pop = 1'b0; data_in = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic  push;
        logic  pop;
        word_t din;
        logic  e_empty;
        logic  e_aempty;
        logic  e_err;
        ptr_t  e_wr;
        ptr_t  e_rd;
        logic  chk_dout;
        word_t e_dout;
    } vec_t;

    vec_t vecs[6];

    initial begin
        push = 1'b0; pop = 1'b0; data_in = '0; reset = 1'b0;
        model_reset();

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_wr_ptr", wr_ptr, 0);
        check("rst_rd_ptr", rd_ptr, 0);
        check("rst_empty", empty, 1);
        check("rst_almost_empty", almost_empty, 1);
        check("rst_full", full, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_error", error, 0);
        @(posedge clk); #1;

        // Directed table: push/pop round trip, then pop-on-empty with push.
        vecs[0] = '{1'b1, 1'b0, 32'h12345678, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 1'b1, 32'h12345678};
        vecs[2] = '{1'b1, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 1'b1, 32'hA5A5A5A5};
        vecs[4] = '{1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 1'b1, 32'hA5A5A5A5};
        vecs[5] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 4'd2, 4'd2, 1'b0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            push = vecs[i].push; pop = vecs[i].pop; data_in = vecs[i].din;
            @(negedge clk);
            check($sformatf("vec%0d_empty", i), empty, vecs[i].e_empty);
            check($sformatf("vec%0d_aempty", i), almost_empty, vecs[i].e_aempty);
            check($sformatf("vec%0d_error", i), error, vecs[i].e_err);
            check($sformatf("vec%0d_wr", i), wr_ptr, vecs[i].e_wr);
            check($sformatf("vec%0d_rd", i), rd_ptr, vecs[i].e_rd);
            if (vecs[i].chk_dout) check($sformatf("vec%0d_dout", i), data_out, vecs[i].e_dout);
            model_check(vecs[i].push, vecs[i].pop);
            @(posedge clk); #1;
            model_update(vecs[i].push, vecs[i].pop, vecs[i].din);
        end

        // Fill to capacity, then overflow without pop.
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            step(1'b1, 1'b0, word_t'(k - 1));
            check($sformatf("fill%0d_aempty", k), almost_empty, k <= 4);
            check($sformatf("fill%0d_afull", k), almost_full, k >= 10);
            check($sformatf("fill%0d_full", k), full, k == 15);
        end
        push = 1'b1; pop = 1'b0; data_in = 32'hDEADBEEF;
        @(negedge clk);
        check("overflow_error", error, 1);
        @(posedge clk); #1;
        model_update(1'b1, 1'b0, 32'hDEADBEEF);
        check("overflow_wr_hold", wr_ptr, 15);
        check("overflow_head", data_out, 0);

        // Full FIFO: simultaneous push+pop for 20 cycles.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, word_t'(100 + i));
        check("pp_full", full, 1);
        check("pp_wr", wr_ptr, 3);
        check("pp_rd", rd_ptr, 4);
        check("pp_head", data_out, 105);

        // Asynchronous reset mid-stream at fill 7.
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, word_t'(200 + i));
        check("fill7_wr", wr_ptr, 7);
        push = 1'b0; pop = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_empty", empty, 1);
        check("async_aempty", almost_empty, 1);
        check("async_full", full, 0);
        check("async_afull", almost_full, 0);
        check("async_wr", wr_ptr, 0);
        check("async_rd", rd_ptr, 0);
        @(posedge clk); #1 reset = 1'b0;
        model_reset();

`ifdef FIFO_ERR_CNT_EN
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, '0);
        check("err_cnt_sat", err_cnt, 255);
        do_reset();
`endif

        // Randomized traffic with shifting push/pop bias to reach both ends.
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = ((i / 200) % 3 == 0) ? 80 : (((i / 200) % 3 == 1) ? 25 : 50);
            step($urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias),
                 word_t'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
